// File: rtl/karatsuba2_iter_mul.sv
// Iterative two-way Karatsuba multiplier (carry-less or unsigned integer).
// Three half-width shift-and-accumulate lanes run in parallel, then recombine into a PIP-deep output pipe.

module karatsuba2_lane #(
    parameter int H = 112,
    parameter int D = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           mode,
    input  logic [H:0]     mcand_in,
    input  logic [H:0]     mplier_in,
    output logic [2*H+1:0] acc
);
    localparam int W = 2 * H + 2;

    logic [W-1:0] mcand_q, acc_q, acc_nxt;
    logic [H:0]   mplier_q;

    // The multiplier shifts right and the multiplicand left by D each step, so bit i
    // of mplier_q always lines up with mcand_q << i; bits past the top fall out as 0.
    always_comb begin
        acc_nxt = acc_q;
        for (int i = 0; i < D; i++) begin
            if (mplier_q[i])
                acc_nxt = mode ? (acc_nxt + (mcand_q << i)) : (acc_nxt ^ (mcand_q << i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load) begin
            mcand_q  <= W'(mcand_in);
            mplier_q <= mplier_in;
            acc_q    <= '0;
        end else if (step) begin
            mcand_q  <= mcand_q << D;
            mplier_q <= mplier_q >> D;
            acc_q    <= acc_nxt;
        end
    end

    assign acc = acc_q;
endmodule

module karatsuba2_iter_mul #(
    parameter int N   = 224,
    parameter int D   = 1,
    parameter int PIP = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] c
);
    localparam int H    = N / 2;
    localparam int W    = 2 * H + 2;
    localparam int W2   = 2 * N;
    localparam int K    = (H + D) / D;
    localparam int CMAX = (K > PIP) ? K : PIP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] P_LAST = CW'((PIP > 0) ? PIP - 1 : 0);

    typedef enum logic [1:0] {IDLE, MUL, COMB, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            mode_q;
    logic            load, step, comb_en;

    logic [2:0][H:0]   mcand, mplier;
    logic [2:0][W-1:0] acc;
    logic [W-1:0]      m;
    logic [W2-1:0]     c_comb;

    logic [PIP:0][W2-1:0] pipe;
    logic [PIP:0]         vld_pipe;

    // Lane 0: a1*c1 (P0), lane 1: b1*d1 (P1), lane 2: middle product S.
    always_comb begin
        mcand[0]  = {1'b0, a[N-1:H]};
        mplier[0] = {1'b0, b[N-1:H]};
        mcand[1]  = {1'b0, a[H-1:0]};
        mplier[1] = {1'b0, b[H-1:0]};
        if (mode) begin
            mcand[2]  = {1'b0, a[N-1:H]} + {1'b0, a[H-1:0]};
            mplier[2] = {1'b0, b[N-1:H]} + {1'b0, b[H-1:0]};
        end else begin
            mcand[2]  = {1'b0, a[N-1:H] ^ a[H-1:0]};
            mplier[2] = {1'b0, b[N-1:H] ^ b[H-1:0]};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lane
        karatsuba2_lane #(.H(H), .D(D)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .step      (step),
            .mode      (mode_q),
            .mcand_in  (mcand[g]),
            .mplier_in (mplier[g]),
            .acc       (acc[g])
        );
    end

    // P0/P1 top bits are always zero, so full-width arithmetic stays exact.
    always_comb begin
        if (mode_q) begin
            m      = acc[2] - acc[0] - acc[1];
            c_comb = (W2'(acc[0]) << N) + (W2'(m) << H) + W2'(acc[1]);
        end else begin
            m      = acc[2] ^ acc[0] ^ acc[1];
            c_comb = (W2'(acc[0]) << N) ^ (W2'(m) << H) ^ W2'(acc[1]);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        comb_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                step = 1'b1;
                if (cnt == K_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = COMB;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            COMB: begin
                comb_en   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = (PIP == 0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (cnt == P_LAST) state_nxt = IDLE;
                else               cnt_nxt   = cnt + CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) mode_q <= mode;
        end
    end

    // A stage only loads when the stage before it holds a fresh result, so the
    // last stage (and hence c) keeps the previous product until the new one lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe     <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= comb_en;
            if (comb_en) pipe[0] <= c_comb;
            for (int k = 1; k <= PIP; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) pipe[k] <= pipe[k-1];
            end
        end
    end

    assign ready = (state == IDLE);
    assign done  = vld_pipe[PIP];
    assign c     = pipe[PIP];
endmodule

// File: tb/tb_karatsuba2_iter_mul.sv
// Scoreboard bench for karatsuba2_iter_mul: directed spec vectors, mid-op reset,
// back-to-back throughput and random vectors against carry-less / integer reference models.

module tb_karatsuba2_iter_mul;
    localparam int TN  = 8;
    localparam int TD  = 2;
    localparam int TP  = 2;
    localparam int TH  = TN / 2;
    localparam int TK  = (TH + 1 + TD - 1) / TD;
    localparam int LAT = TK + 1 + TP;
    localparam int PER = TK + 2 + TP;
    localparam int TW  = 2 * TN;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
    logic [TN-1:0] a = '0, b = '0;
    logic          ready, done;
    logic [TW-1:0] c;

    karatsuba2_iter_mul #(.N(TN), .D(TD), .PIP(TP)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] exp;
        int            t;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0, n_bad = 0, cyc = 0, last_acc = -1;
    bit            b2b = 1'b0;
    logic [TW-1:0] last_c = '0;

    task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [TW-1:0] ref_mul(input logic m, input logic [TN-1:0] x, input logic [TN-1:0] y);
        logic [TW-1:0] r;
        r = '0;
        if (m) r = TW'(x) * TW'(y);
        else
            for (int i = 0; i < TN; i++)
                if (y[i]) r = r ^ (TW'(x) << i);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on done, checks hold/busy otherwise, pushes on acceptance.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("qdepth_at_done", TW'(exp_q.size()), TW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", c, e.exp);
                chk("latency", TW'(cyc - e.t), TW'(LAT));
            end
            chk("ready_at_done", TW'(ready), TW'(1));
            last_c = c;
        end else begin
            chk("hold_c", c, last_c);
            if (exp_q.size() != 0) chk("busy_ready", TW'(ready), TW'(0));
        end
        if (rst && start && ready) begin
            e.exp = ref_mul(mode, a, b);
            e.t   = cyc + 1;
            exp_q.push_back(e);
            if (b2b && last_acc >= 0) chk("throughput", TW'(cyc + 1 - last_acc), TW'(PER));
            last_acc = cyc + 1;
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 4 * PER + 10 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        chk("idle_timeout", TW'(ok), TW'(1));
        if (!ok) exp_q.delete();
    endtask

    task automatic run_op(input logic m, input logic [TN-1:0] x, input logic [TN-1:0] y, input bit poke);
        @(posedge clk); #1;
        mode = m; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; a = TN'($urandom); b = TN'($urandom);
        if (poke) begin
            start = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #1;
        chk("rst_c", c, '0);
        chk("rst_ready", TW'(ready), TW'(1));
        chk("rst_done", TW'(done), TW'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run_op(1'b0, 8'h03, 8'h03, 1'b0);
        chk("clmul_03x03", c, 16'h0005);
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0);
        chk("int_FFxFF", c, 16'hFE01);
        run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
        chk("clmul_FFxFF", c, 16'h5555);
        run_op(1'b1, 8'h00, 8'hA7, 1'b0);
        chk("int_00xA7", c, 16'h0000);
        run_op(1'b1, 8'h80, 8'h80, 1'b1);
        chk("int_80x80_busy_poke", c, 16'h4000);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        mode = 1'b1; a = '1; b = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        last_c = '0;
        #1;
        chk("midrst_c", c, '0);
        chk("midrst_done", TW'(done), TW'(0));
        chk("midrst_ready", TW'(ready), TW'(1));
        @(posedge clk); #1 rst = 1'b1;
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0);
        chk("post_rst_int_FFxFF", c, 16'hFE01);

        // Back-to-back with start held high and operands changing every cycle.
        b2b = 1'b1;
        last_acc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 6 * PER; i++) begin
            mode = 1'($urandom);
            a = TN'($urandom);
            b = TN'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        b2b = 1'b0;

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 150; i++)
                run_op(1'(m), TN'($urandom), TN'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/karatsuba2_iter_mul.md
# karatsuba2_iter_mul

Parametrised, iterative two-way Karatsuba multiplier for N-bit operands. It supports both carry-less (GF(2)[x]) and unsigned-integer products, selected per operation. The block computes the three half-width sub-products concurrently, D multiplier bits per cycle, then recombines them and passes the 2N-bit result through PIP output register stages. It uses a start/ready/done handshake and is the iterative, low-area option in the large-integer multiplier library.

## Interface
- N, 224, operand width; must be even and ≥ 4; H = N/2.
- D, 1, multiplier bits consumed per iteration cycle; 1 ≤ D ≤ H+1.
- PIP, 3, extra output register stages after recombination; ≥ 0.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- mode  in  1  0 = carry-less (XOR), 1 = unsigned integer; sampled with start.
- a  in  N  operand A; sampled with start.
- b  in  N  operand B; sampled with start.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when c becomes valid.
- c  out  2N  product; holds its value until the next result is written.

## Operation
- Split: a1=a[N-1:H], b1=a[H-1:0], c1=b[N-1:H], d1=b[H-1:0].
- P0 = a1·c1, P1 = b1·d1, each 2H bits.
- Carry-less: S = (a1^b1)·(c1^d1), 2H bits; M = S ^ P0 ^ P1; c = (P0<<N) ^ (M<<H) ^ P1.
- Integer: sa=a1+b1 and sc=c1+d1, each H+1 bits; S = sa·sc, 2H+2 bits; M = S − P0 − P1 (never negative, fits 2H+1 bits); c = (P0<<N) + (M<<H) + P1, exact in 2N bits.
- Operands, mode and half-sums are latched at acceptance. Inputs may change afterwards without effect.
- Shift-and-accumulate: each MUL cycle processes multiplier bits [j·D, j·D+D−1] for all three products at once. Multiplier bits at or beyond a factor's width are treated as 0. Accumulation uses XOR in mode 0 and addition in mode 1.
- K = ceil((H+1)/D) iterations. The middle product has H+1 multiplier bits in integer mode. P0 and P1 ignore their extra bit position.
- FSM states:
  - IDLE: ready=1. start=1 latches operands, clears the accumulators, and moves to MUL.
  - MUL: runs K cycles with a digit counter 0..K−1, then moves to COMB.
  - COMB: computes c per mode into pipeline stage 0, then moves to DRAIN, or to IDLE if PIP=0.
  - DRAIN: shifts through PIP stages, then moves to IDLE.
- c and done are written on the same edge. done is high for exactly one cycle.
- start while not ready is ignored: no queueing, no error.
- Reset (any time, including mid-operation): state=IDLE, ready=1, done=0, c=0, and all accumulators, counter and pipeline registers are 0. No partial result is ever emitted.

## Timing
- Start accepted at edge t means ready=0 from t until the final edge.
- c is valid and done=1 after edge t+K+1+PIP.
- ready returns to 1 after the same edge. A new start may be accepted at the next edge, t+K+2+PIP, giving back-to-back throughput of one result per K+2+PIP cycles.
- Example, N=8, D=1, PIP=0: K=5, and done is high after edge t+6.
- Default configuration (224, 1, 3): K=113, and done is high after edge t+117.
- After reset release, ready=1 and c=0 until the first result.
- Longest combinational path: the D-bit partial-product accumulate in MUL, or the 2N-bit recombination in COMB.

## Test plan
- N=8, D=1, PIP=0, mode 0: a=0x03, b=0x03 -> c=0x0005, done exactly 6 cycles after acceptance.
- N=8, D=1, PIP=0, mode 1: a=0xFF, b=0xFF -> c=0xFE01. In mode 0, the same operands -> c=0x5555.
- N=8, D=2, PIP=2, mode 1: a=0x00, b=0xA7 -> c=0x0000. Then a=0x80, b=0x80 -> c=0x4000, done 6 cycles after acceptance (K=3). Pulse start during busy: no effect, ready stays 0.
- Reset mid-operation: with the default configuration, start a=b=all-ones in mode 1, then assert rst at cycle 50 -> c=0, done=0, ready=1 immediately. After release, the next start runs clean and matches the golden model.
- Back-to-back: hold start=1 continuously with changing operands -> one result per K+2+PIP cycles, each matching the operands sampled at its own acceptance edge.
- Random regression: 10k vectors per mode for (N,D,PIP) ∈ {(8,1,0), (16,3,1), (224,1,3), (224,8,3)}, compared against carry-less and integer reference models.
